// File: rtl/aer_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aer_rx_fifo                                                |
// | Description : Two-word (Y then X) AER handshake receiver feeding an      |
// |               event FIFO of {pol, x, y} plus timestamp.                  |
// |               Optional macro AER_POLARITY_EN splits polarity from X.     |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module aer_rx_fifo #(
    parameter int Y_W    = 8,
    parameter int X_W    = 9,
    parameter int TS_W   = 32,
    parameter int SETTLE = 16,
    parameter int DEPTH  = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [((Y_W > X_W) ? Y_W : X_W)-1:0]   AER_bus,
    input  logic                                   REQ,
    input  logic                                   SEL,
    input  logic [TS_W-1:0]                        time_stamp,
    output logic                                   ACK,
    output logic                                   evt_valid,
    input  logic                                   evt_ready,
    output logic [X_W+Y_W:0]                       evt_data,
    output logic [TS_W-1:0]                        evt_ts,
    output logic [$clog2(DEPTH):0]                 fifo_level,
    output logic [15:0]                            orphan_cnt
);

    localparam int c_BUS_W = (Y_W > X_W) ? Y_W : X_W;
    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_LW    = c_AW + 1;
    localparam int c_EW    = 1 + X_W + Y_W;
    localparam int c_CNT_W = $clog2(SETTLE + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(SETTLE - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        Y_SETTLE = 3'd1,
        X_SETTLE = 3'd2,
        X_STALL  = 3'd3,
        WAIT_REL = 3'd4
    } state_t;

    logic                 r_req_m, r_req_s, r_sel_m, r_sel_s;
    logic [c_BUS_W-1:0]   r_bus_m, r_bus_s;
    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [Y_W-1:0]       r_y;
    logic                 r_row_valid;
    logic                 r_ack;
    logic [15:0]          r_orphan;
    logic [c_EW-1:0]      r_hold_evt;
    logic [TS_W-1:0]      r_hold_ts;

    logic [c_EW-1:0]      r_mem_evt [DEPTH];
    logic [TS_W-1:0]      r_mem_ts  [DEPTH];
    logic [c_AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [c_LW-1:0]      r_level;

    logic [X_W-1:0]       w_x;
    logic                 w_pol;
    logic                 w_full, w_pop, w_can_push, w_push, w_settled;
    logic [c_EW-1:0]      w_push_evt;
    logic [TS_W-1:0]      w_push_ts;

`ifdef AER_POLARITY_EN
    assign w_pol = r_bus_s[0];
    assign w_x   = {1'b0, r_bus_s[X_W-1:1]};
`else
    assign w_pol = 1'b0;
    assign w_x   = r_bus_s[X_W-1:0];
`endif

    // REQ synchroniser resets to the released level so reset never looks like a request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_m <= 1'b1;
            r_req_s <= 1'b1;
            r_sel_m <= 1'b0;
            r_sel_s <= 1'b0;
            r_bus_m <= '0;
            r_bus_s <= '0;
        end else begin
            r_req_m <= REQ;
            r_req_s <= r_req_m;
            r_sel_m <= SEL;
            r_sel_s <= r_sel_m;
            r_bus_m <= AER_bus;
            r_bus_s <= r_bus_m;
        end
    end

    assign w_full     = (r_level == c_LW'(DEPTH));
    assign w_pop      = evt_valid && evt_ready;
    assign w_can_push = !w_full || w_pop;
    assign w_settled  = (r_cnt == c_CNT_LAST);
    assign w_push     = ((r_state == X_SETTLE) && w_settled && r_row_valid && w_can_push) ||
                        ((r_state == X_STALL) && w_can_push);
    assign w_push_evt = (r_state == X_STALL) ? r_hold_evt : {w_pol, w_x, r_y};
    assign w_push_ts  = (r_state == X_STALL) ? r_hold_ts  : time_stamp;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_y         <= '0;
            r_row_valid <= 1'b0;
            r_ack       <= 1'b1;
            r_orphan    <= '0;
            r_hold_evt  <= '0;
            r_hold_ts   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!r_req_s) begin
                        r_cnt   <= '0;
                        r_state <= r_sel_s ? X_SETTLE : Y_SETTLE;
                    end
                end
                Y_SETTLE: begin
                    if (w_settled) begin
                        r_y         <= r_bus_s[Y_W-1:0];
                        r_row_valid <= 1'b1;
                        r_ack       <= 1'b0;
                        r_state     <= WAIT_REL;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                X_SETTLE: begin
                    if (w_settled) begin
                        if (!r_row_valid) begin
                            if (r_orphan != 16'hFFFF)
                                r_orphan <= r_orphan + 16'd1;
                            r_ack   <= 1'b0;
                            r_state <= WAIT_REL;
                        end else if (w_can_push) begin
                            r_ack   <= 1'b0;
                            r_state <= WAIT_REL;
                        end else begin
                            r_hold_evt <= w_push_evt;
                            r_hold_ts  <= time_stamp;
                            r_state    <= X_STALL;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                X_STALL: begin
                    if (w_can_push) begin
                        r_ack   <= 1'b0;
                        r_state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (r_req_s) begin
                        r_ack   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            r_level <= r_level + c_LW'(w_push) - c_LW'(w_pop);
        end
    end

    // At full a push only happens alongside a pop, so overwriting the head slot is safe
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_evt[r_wr_ptr] <= w_push_evt;
            r_mem_ts[r_wr_ptr]  <= w_push_ts;
        end
    end

    assign evt_valid  = (r_level != '0);
    assign evt_data   = evt_valid ? r_mem_evt[r_rd_ptr] : '0;
    assign evt_ts     = evt_valid ? r_mem_ts[r_rd_ptr]  : '0;
    assign fifo_level = r_level;
    assign ACK        = r_ack;
    assign orphan_cnt = r_orphan;

endmodule
`default_nettype wire

// File: doc/aer_rx_fifo.md
AER_RX_FIFO -- requirements
Module: aer_rx_fifo

Interface
REQ-001 Parameter Y_W, default 8, row (Y) address width.
REQ-002 Parameter X_W, default 9, column word width on the bus, polarity bit included.
REQ-003 Parameter TS_W, default 32, timestamp width.
REQ-004 Parameter SETTLE, default 16, bus-settle delay in clk cycles after synchronised REQ assertion.
REQ-005 Parameter DEPTH, default 16, event FIFO depth; power of two, at least 2.
REQ-006 Ports SHALL be one per line: name  direction  width  meaning.
  clk  in  1  single clock; all logic on rising edge.
  rst  in  1  synchronous reset, active-high.
  AER_bus  in  max(Y_W,X_W)  asynchronous AER address bus.
  REQ  in  1  asynchronous request, active-low.
  SEL  in  1  asynchronous word select; 0 = Y word, 1 = X word.
  time_stamp  in  TS_W  free-running timestamp.
  ACK  out  1  acknowledge to sensor, active-low.
  evt_valid  out  1  FIFO head valid.
  evt_ready  in  1  consumer accepts head.
  evt_data  out  1+X_W+Y_W  {pol, x, y} of head event.
  evt_ts  out  TS_W  timestamp of head event.
  fifo_level  out  $clog2(DEPTH)+1  occupancy.
  orphan_cnt  out  16  X words received with no prior Y since reset.

Function
REQ-007 REQ, SEL and AER_bus SHALL each pass through a 2-flop synchroniser; the FSM uses only synchronised values.
REQ-008 FSM states SHALL be IDLE, Y_SETTLE, X_SETTLE, X_STALL, WAIT_REL.
REQ-009 IDLE: REQ_s=0 with SEL_s=0 -> Y_SETTLE; REQ_s=0 with SEL_s=1 -> X_SETTLE; settle counter cleared on entry.
REQ-010 Y_SETTLE: after SETTLE cycles, latch y <= AER_bus_s[Y_W-1:0], set row_valid, drive ACK=0, -> WAIT_REL.
REQ-011 X_SETTLE: after SETTLE cycles, latch x word and time_stamp in the same cycle; if FIFO not full, push and drive ACK=0 -> WAIT_REL; if full -> X_STALL.
REQ-012 X_STALL: ACK held 1; the push and ACK=0 take place in the first cycle the FIFO is not full; the timestamp keeps its original latched value.
REQ-013 X word with row_valid=0: no push; orphan_cnt increments, saturating at 16'hFFFF; ACK=0 -> WAIT_REL.
REQ-014 WAIT_REL: when REQ_s=1, drive ACK=1 -> IDLE.
REQ-015 row_valid and y persist across several X words; a new Y word overwrites y.
REQ-016 FIFO: push and pop in the same cycle SHALL be legal at any level, including full (pop frees the slot for that push) and empty (write-through not required).
REQ-017 A pop occurs when evt_valid=1 and evt_ready=1; evt_data and evt_ts SHALL be stable while evt_valid=1 and evt_ready=0.
REQ-018 Latency from the latch cycle to evt_valid SHALL be 1 cycle when the FIFO was empty.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; fifo_level SHALL equal pushes minus pops.

Reset
REQ-020 While rst=1 the block SHALL be in this state:
  - FSM = IDLE, ACK=1, evt_valid=0, fifo_level=0, orphan_cnt=0, row_valid=0, synchronisers cleared.
  - evt_data and evt_ts = 0.
REQ-021 rst asserted mid-handshake SHALL abort the handshake and release ACK to 1; a partly captured event is discarded.

Configuration
REQ-022 Macro AER_POLARITY_EN defined: pol = AER_bus_s[0], x = AER_bus_s[X_W-1:1] zero-extended to X_W.
REQ-023 Macro AER_POLARITY_EN undefined: x = AER_bus_s[X_W-1:0], pol = 0.

Verification
REQ-024 Y=0x2A handshake, then X=0x105 at time_stamp 1000 -> evt_data y=0x2A, evt_ts=1000, ACK low about SETTLE+3 cycles after REQ falls; with the macro pol=1, x=0x082.
REQ-025 Y=0x10, then three X words -> three events all with y=0x10, in order.
REQ-026 evt_ready=0, DEPTH+1 X events -> last ACK stays 1 (X_STALL); one pop -> ACK=0 next cycle, FIFO full again, order preserved.
REQ-027 X word right after rst -> no event, orphan_cnt=1, handshake completes.
REQ-028 rst pulse during WAIT_REL with ACK=0 -> ACK=1, fifo_level=0 the next cycle.
REQ-029 Push and pop in the same cycle at full and at level 1 -> fifo_level unchanged, data intact.
